// File: rtl/seq_detect_prog.sv
// ============================================================================
// seq_detect_prog
// ----------------------------------------------------------------------------
// Programmable serial bit-pattern detector. Watches a qualified serial bit
// stream for a runtime-loadable pattern of 1..MAX_LEN bits and reports each
// match as a registered one-cycle pulse plus a saturating match counter.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (4..32)
//   CNT_W    width of the match counter
//   LEN_W    width of length fields (derived, do not override)
//
// Ports
//   clk          in   single clock, rising-edge
//   reset        in   asynchronous active-low reset, synchronous release
//   inp_bit      in   serial data bit
//   in_valid     in   inp_bit qualifier
//   cfg_load     in   one-cycle strobe capturing cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  in   pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      in   pattern length
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      in   synchronous clear of match_count
//   seq_seen     out  registered one-cycle match pulse
//   match_count  out  saturating match count
//   cfg_err      out  high while the active configuration is invalid
//
// Input handshake: in_valid qualifies inp_bit and there is no backpressure.
// Every rising edge with in_valid=1 (and cfg_load=0) consumes exactly one
// bit; edges with in_valid=0 consume nothing and leave the history untouched.
// ============================================================================
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    // Power-on configuration reproduces the legacy fixed 1011 detector.
    localparam logic [MAX_LEN-1:0] DEF_PAT  = MAX_LEN'(4'b1011);
    localparam logic [LEN_W-1:0]   DEF_LEN  = LEN_W'(4);
    localparam logic [LEN_W-1:0]   FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_cfg_err;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_seq_seen;
    logic [CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Combinational next-history and match evaluation
    // ------------------------------------------------------------------
    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_new_cfg_err;

    // cfg_load takes priority: a bit presented on a load edge is discarded.
    assign w_accept    = in_valid && !cfg_load;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], inp_bit};
    assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);

    // Mask selects the low r_len history bits; pattern bits at or above the
    // active length are don't-cares. When r_len is out of range the mask is
    // meaningless, but the match is gated by r_cfg_err anyway.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // Match is judged on the post-shift history so that seq_seen rises on
    // the same edge that accepts the final pattern bit.
    assign w_match = w_accept
                  && !r_cfg_err
                  && (w_fill_next >= r_len)
                  && ((w_hist_next & w_mask) == (r_pat & w_mask));

    assign w_new_cfg_err = (cfg_len == '0) || (cfg_len > FILL_MAX);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat     <= DEF_PAT;
            r_len     <= DEF_LEN;
            r_ovl     <= 1'b1;
            r_cfg_err <= 1'b0;
        end else if (cfg_load) begin
            r_pat     <= cfg_pattern;
            r_len     <= cfg_len;
            r_ovl     <= cfg_overlap;
            r_cfg_err <= w_new_cfg_err;
        end
    end

    // ------------------------------------------------------------------
    // History shift register, fill counter and match pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_seq_seen <= 1'b0;
        end else if (cfg_load) begin
            // A new configuration starts from an empty history.
            r_hist     <= '0;
            r_fill     <= '0;
            r_seq_seen <= 1'b0;
        end else if (w_accept) begin
            r_hist     <= w_hist_next;
            // Non-overlapping mode restarts the fill count after a match so
            // the next match needs r_len fresh bits; the history itself is
            // kept because the fill gate alone prevents reuse of old bits.
            if (w_match && !r_ovl) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
            r_seq_seen <= w_match;
        end else begin
            r_seq_seen <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating match counter; clear beats a coincident match.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_match && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign seq_seen    = r_seq_seen;
    assign match_count = r_count;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog. A second instance with a 2-bit counter
// shares every input so counter saturation can be observed alongside the
// main instance.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               inp_bit = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic        seq_seen, seq_seen2;
  logic [15:0] match_count;
  logic [1:0]  match_count2;
  logic        cfg_err, cfg_err2;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq_seen(seq_seen),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq_seen(seq_seen2),
    .match_count(match_count2), .cfg_err(cfg_err2)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    inp_bit  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic gap(input string tag);
    in_valid = 1'b0;
    step();
    check(tag, {31'd0, seq_seen}, 32'd0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    step();
    cfg_load    = 1'b0;
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  // Stream n bits, first bit = bits[n-1]; exp_pulse[i] is seq_seen after bits[i].
  task automatic stream(input string tag, input logic [31:0] bits, input int n,
                        input logic [31:0] exp_pulse);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({31'd0, exp_pulse[i]});
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      check(tag, {31'd0, seq_seen}, exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();

    // reset state
    check("rst_seen", {31'd0, seq_seen}, 32'd0);
    check("rst_count", {16'd0, match_count}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);

    // default 1011 overlapping
    stream("def_stream", 32'b1011011, 7, 32'b0001001);
    check("def_count", {16'd0, match_count}, 32'd2);
    gap("def_idle");

    // non-overlap 1011
    load(8'b1011, 4, 1'b0);
    check("load_keeps_count", {16'd0, match_count}, 32'd2);
    clear_count();
    check("cnt_clr", {16'd0, match_count}, 32'd0);
    stream("novl1011", 32'b1011011, 7, 32'b0001000);
    check("novl1011_count", {16'd0, match_count}, 32'd1);

    // 101 overlap vs non-overlap
    load(8'b101, 3, 1'b1);
    stream("ovl101", 32'b10101, 5, 32'b00101);
    check("ovl101_count", {16'd0, match_count}, 32'd3);
    load(8'b101, 3, 1'b0);
    stream("novl101", 32'b10101, 5, 32'b00100);
    check("novl101_count", {16'd0, match_count}, 32'd4);

    // gapped valid
    load(8'b1011, 4, 1'b1);
    send(1'b1); check("gap_b1", {31'd0, seq_seen}, 32'd0);
    gap("gap_g1");
    send(1'b0); check("gap_b2", {31'd0, seq_seen}, 32'd0);
    gap("gap_g2");
    gap("gap_g3");
    send(1'b1); check("gap_b3", {31'd0, seq_seen}, 32'd0);
    gap("gap_g4");
    send(1'b1); check("gap_b4", {31'd0, seq_seen}, 32'd1);
    gap("gap_after");
    check("gap_count", {16'd0, match_count}, 32'd5);

    // max length A5
    load(8'hA5, 8, 1'b1);
    stream("max_len", 32'hA5, 8, 32'b00000001);
    // don't-care upper pattern bits: F3 with len 3 compares only 011
    load(8'hF3, 3, 1'b1);
    stream("dont_care", 32'b011, 3, 32'b001);

    // invalid lengths
    load(8'hFF, 0, 1'b1);
    check("len0_err", {31'd0, cfg_err}, 32'd1);
    stream("len0_stream", 32'hFFFF, 16, 32'd0);
    load(8'hFF, 9, 1'b1);
    check("len9_err", {31'd0, cfg_err}, 32'd1);
    stream("len9_stream", 32'hFFFF, 16, 32'd0);
    check("err_count", {16'd0, match_count}, 32'd7);
    load(8'b1011, 4, 1'b1);
    check("err_cleared", {31'd0, cfg_err}, 32'd0);

    // cfg_load collides with a valid bit that would complete 1011
    stream("pre_coll", 32'b101, 3, 32'b000);
    inp_bit = 1'b1; in_valid = 1'b1; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0; in_valid = 1'b0;
    check("coll_seen", {31'd0, seq_seen}, 32'd0);
    stream("coll_refill", 32'b011, 3, 32'b000);
    stream("coll_match", 32'b1011, 4, 32'b0001);

    // cnt_clr on a match edge
    stream("clr_pre", 32'b101, 3, 32'b000);
    check("clr_pre_count", {16'd0, match_count}, 32'd8);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    check("clr_match_seen", {31'd0, seq_seen}, 32'd1);
    check("clr_match_count", {16'd0, match_count}, 32'd0);
    check("clr_match_count2", {30'd0, match_count2}, 32'd0);

    // back-to-back and saturation with len 1
    load(8'b1, 1, 1'b1);
    stream("b2b", 32'b11111, 5, 32'b11111);
    check("sat_count16", {16'd0, match_count}, 32'd5);
    check("sat_count2", {30'd0, match_count2}, 32'd3);

    // asynchronous reset mid-stream
    stream("pre_rst", 32'b101, 3, 32'b101);
    reset = 1'b0;
    #2;
    check("async_seen", {31'd0, seq_seen}, 32'd0);
    check("async_count", {16'd0, match_count}, 32'd0);
    check("async_count2", {30'd0, match_count2}, 32'd0);
    reset = 1'b1;
    stream("post_rst1", 32'b1, 1, 32'b0);
    stream("post_rst", 32'b011, 3, 32'b001);
    check("post_rst_count", {16'd0, match_count}, 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector, parametrised successor to the fixed 1011 detector. It watches a qualified serial bit stream for a runtime-loadable pattern of 1..MAX_LEN bits. Matching is overlapping or non-overlapping, and a saturating counter tracks matches. It sits on the same serial input path as the fixed-pattern detectors and feeds pulse/count status to the control block.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 4..32.
- CNT_W, 16: width of match counter.
- LEN_W, $clog2(MAX_LEN+1): width of length fields (derived; do not override).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserting low clears all state immediately; release is synchronous to clk).
- inp_bit  in  1  serial data bit.
- in_valid  in  1  inp_bit qualifier; a bit is accepted only on an edge where in_valid=1.
- cfg_load  in  1  one-cycle strobe; captures cfg_pattern, cfg_len, cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- seq_seen  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  high while the active configuration is invalid.

## Operation
- Internal state:
  - pat_r, len_r and ovl_r hold the active configuration.
  - hist is a MAX_LEN shift register.
  - fill is a fill counter (0..MAX_LEN, saturating).
- Reset values:
  - pat_r = 'b1011 in bits [3:0] with upper bits 0, len_r = 4, ovl_r = 1.
  - hist = 0, fill = 0, seq_seen = 0, match_count = 0, cfg_err = 0.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], inp_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift history:
  - cfg_err=0, fill_next >= len_r, and hist_next[len_r-1:0] == pat_r[len_r-1:0].
- On a match:
  - seq_seen <= 1.
  - match_count increments unless it equals 2^CNT_W-1, where it holds.
  - If ovl_r=0, fill <= 0, so the next match needs len_r fresh bits. hist is not cleared.
  - If ovl_r=1, fill is unaffected.
- No accepted bit (in_valid=0):
  - hist and fill hold.
  - seq_seen <= 0.
- cfg_load=1:
  - Captures the configuration, clears hist and fill, and forces seq_seen <= 0.
  - A concurrent inp_bit is discarded. cfg_load wins over in_valid.
- cfg_err:
  - Set on load when cfg_len == 0 or cfg_len > MAX_LEN. Cleared on load of a valid length.
  - While set, no matches occur. Shifting continues.
- cnt_clr:
  - Sets match_count <= 0. If a match occurs on the same edge, the clear wins and the result is 0.
  - seq_seen still pulses on that edge.
- Don't-care bits: cfg_pattern bits at or above cfg_len are ignored for comparison.

## Timing
- Detection latency: seq_seen rises on the clk edge that accepts the final pattern bit and is high for exactly the following cycle. This matches the Moore timing of the fixed detector.
- Back-to-back: in overlap mode, consecutive-cycle matches are possible, e.g. len 1 or pattern 11 on a run of 1s. seq_seen then stays high across consecutive cycles, one cycle per match.
- Count visibility: match_count updates on the same edge as seq_seen.
- Configuration: a new configuration takes effect for bits accepted from the edge after cfg_load. The first match after a load requires at least len_r accepted bits.
- Reset mid-stream: reset asserted low clears all state and outputs within the same cycle, asynchronously. Nothing is retained.
- Fill saturation: fill saturates at MAX_LEN with no wrap. hist discards the oldest bit.
- Counter saturation: match_count does not wrap at 2^CNT_W-1.

## Test plan
- Default config: after reset, stream 1,0,1,1,0,1,1 with in_valid=1 -> seq_seen pulses after bit 4 and bit 7 (overlap); match_count=2.
- Non-overlap: cfg_load pattern=1011, len=4, overlap=0; stream 1,0,1,1,0,1,1 -> one pulse after bit 4; match_count=1. Same with pattern 101, len 3, stream 10101: overlap gives 2 matches, non-overlap gives 1.
- Gapped valid: stream 1,0,1,1 with in_valid=0 cycles inserted between bits -> exactly one pulse, on the edge accepting the last 1. seq_seen is 0 during the gaps.
- Max length and invalid config:
  - load len=MAX_LEN with pattern 'hA5 (MAX_LEN=8) -> match after exactly those 8 bits.
  - load len=0 -> cfg_err=1 and no pulses on any stream.
  - load len=9 -> cfg_err=1.
- Collisions:
  - cfg_load with in_valid=1 -> that bit is ignored; fill restarts at 0.
  - cnt_clr on a match edge -> seq_seen=1 and match_count=0.
- Saturation and reset: with CNT_W=2, drive 5 matches -> match_count holds at 3. Assert reset low mid-pattern (after 1,0,1), release, send 1 -> no match. match_count=0 and the pattern is back to 1011/len 4.
